// File: rtl/sid_pkg.sv
// Constants and types shared by the SID voice datapath: phase accumulator
// sequencer and waveform stage.
package sid_pkg;

  localparam int NUM_VOICES = 3;
  localparam int ACC_W      = 24;
  localparam int FREQ_W     = 16;
  localparam int VOICE_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef logic [VOICE_W-1:0] voice_idx_t;
  typedef logic [ACC_W-1:0]   acc_t;
  typedef logic [FREQ_W-1:0]  freq_t;

  localparam voice_idx_t LAST_VOICE = voice_idx_t'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    SYNC = 2'd2,
    EMIT = 2'd3
  } state_e;

  // Voice whose accumulator MSB rise hard-syncs voice v (ring order).
  function automatic int sync_src(input int v);
    return (v + NUM_VOICES - 1) % NUM_VOICES;
  endfunction

endpackage

// File: rtl/voice_accum_seq.sv
// Per-sample sweep over all voice phase accumulators with one shared adder,
// SID hard sync / test-bit clear, and valid/ready streaming of the results.
module voice_accum_seq
  import sid_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         tick_i,
  input  logic [NUM_VOICES*FREQ_W-1:0] freq_i,
  input  logic [NUM_VOICES-1:0]        sync_i,
  input  logic [NUM_VOICES-1:0]        test_i,
  input  logic                         ready_i,
  output logic                         valid_o,
  output logic [ACC_W-1:0]             acc_o,
  output logic [VOICE_W-1:0]           voice_o,
  output logic                         busy_o,
  output logic                         overrun_o
);

  state_e                state_q, state_d;
  voice_idx_t            vcnt_q, vcnt_d;
  acc_t                  acc_q [NUM_VOICES];
  acc_t                  acc_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] rise_q, rise_d;
  logic                  valid_q, valid_d;
  acc_t                  acc_out_q, acc_out_d;
  voice_idx_t            voice_out_q, voice_out_d;
  logic                  overrun_q, overrun_d;

  // Shared adder: serves the voice selected by the sweep counter.
  freq_t                 freq_sel;
  acc_t                  add_sum;
  logic [NUM_VOICES-1:0] sync_hit;
  voice_idx_t            next_voice;

  assign freq_sel   = freq_i[int'(vcnt_q)*FREQ_W +: FREQ_W];
  assign add_sum    = acc_q[vcnt_q] + {{(ACC_W-FREQ_W){1'b0}}, freq_sel};
  assign next_voice = voice_out_q + 1'b1;

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      sync_hit[v] = sync_i[v] & rise_q[sync_src(v)];
    end
  end

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    vcnt_d      = vcnt_q;
    acc_d       = acc_q;
    rise_d      = rise_q;
    valid_d     = valid_q;
    acc_out_d   = acc_out_q;
    voice_out_d = voice_out_q;
    overrun_d   = overrun_q;

    // A tick arriving mid-sweep is dropped and only flagged.
    if (tick_i && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (tick_i) begin
          state_d = ADD;
          vcnt_d  = '0;
        end
      end

      ADD: begin
        if (test_i[vcnt_q]) begin
          acc_d[vcnt_q]  = '0;
          rise_d[vcnt_q] = 1'b0;
        end else begin
          acc_d[vcnt_q]  = add_sum;
          rise_d[vcnt_q] = ~acc_q[vcnt_q][ACC_W-1] & add_sum[ACC_W-1];
        end
        if (vcnt_q == LAST_VOICE) begin
          state_d = SYNC;
          vcnt_d  = '0;
        end else begin
          vcnt_d = vcnt_q + 1'b1;
        end
      end

      SYNC: begin
        // All syncs use this sweep's rise flags and land together.
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (sync_hit[v]) acc_d[v] = '0;
        end
        valid_d     = 1'b1;
        voice_out_d = '0;
        acc_out_d   = sync_hit[0] ? '0 : acc_q[0];
        state_d     = EMIT;
      end

      EMIT: begin
        if (valid_q && ready_i) begin
          if (voice_out_q == LAST_VOICE) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end else begin
            voice_out_d = next_voice;
            acc_out_d   = acc_q[next_voice];
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the accumulator array is reset explicitly; it is a handful of
  // flops, and downstream relies on every voice starting its phase at 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      vcnt_q      <= '0;
      rise_q      <= '0;
      valid_q     <= 1'b0;
      acc_out_q   <= '0;
      voice_out_q <= '0;
      overrun_q   <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) acc_q[v] <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed by the combinational block.
      state_q     <= state_d;
      vcnt_q      <= vcnt_d;
      rise_q      <= rise_d;
      valid_q     <= valid_d;
      acc_out_q   <= acc_out_d;
      voice_out_q <= voice_out_d;
      overrun_q   <= overrun_d;
      for (int v = 0; v < NUM_VOICES; v++) acc_q[v] <= acc_d[v];
    end
  end

  assign valid_o   = valid_q;
  assign acc_o     = acc_out_q;
  assign voice_o   = voice_out_q;
  assign busy_o    = (state_q != IDLE);
  assign overrun_o = overrun_q;

endmodule
